// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient} for HI/LO and stalls the pipeline while busy.
module div_seq #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] DBZ_QUOT = {WIDTH{1'b1}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DBZ  = 2'd1;
    localparam logic [1:0] ON   = 2'd2;
    localparam logic [1:0] END  = 2'd3;

    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;   // dividend, shifted out MSB-first; quotient shifts in
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               dbz_q, dbz_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     shifted, diff;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    always_comb begin
        mag1     = (signed_div && opdata1[WIDTH-1]) ? (~opdata1 + 1'b1) : opdata1;
        mag2     = (signed_div && opdata2[WIDTH-1]) ? (~opdata2 + 1'b1) : opdata2;
        shifted  = {rem_q, dvd_q[WIDTH-1]};
        diff     = shifted - {1'b0, dvs_q};
        quot_fix = qneg_q ? (~dvd_q + 1'b1) : dvd_q;
        rem_fix  = rneg_q ? (~rem_q + 1'b1) : rem_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dbz_d    = dbz_q;
        result_d = result_q;
        ready_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !annul) begin
                    dvs_d  = mag2;
                    rem_d  = '0;
                    cnt_d  = '0;
                    qneg_d = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                    rneg_d = signed_div & opdata1[WIDTH-1];
                    if (opdata2 == '0) begin
                        // Divide-by-zero returns the raw dividend as remainder.
                        state_d = DBZ;
                        dvd_d   = opdata1;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ON;
                        dvd_d   = mag1;
                        dbz_d   = 1'b0;
                    end
                end
            end
            ON: begin
                if (annul) begin
                    state_d = IDLE;
                end else begin
                    rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == LAST) begin
                        state_d = END;
                    end
                end
            end
            DBZ: begin
                state_d = annul ? IDLE : END;
            end
            END: begin
                state_d = IDLE;
                if (!annul) begin
                    ready_d  = 1'b1;
                    result_d = dbz_q ? {dvd_q, DBZ_QUOT} : {rem_fix, quot_fix};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dbz_q    <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dbz_q    <= dbz_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    // annul drops stall in the same cycle so the flush is not held off.
    assign stall  = ~annul & (((state_q == IDLE) & start) | (state_q == ON) | (state_q == DBZ));
    assign result = result_q;
    assign ready  = ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, stall length, signed/unsigned results,
// divide-by-zero, overflow, annul, back-to-back and asynchronous reset.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] opdata1 = '0;
    logic [31:0] opdata2 = '0;
    logic [63:0] result;
    logic        ready;
    logic        stall;

    int vectors = 0;
    int errors  = 0;

    div_seq #(
        .WIDTH   (32),
        .DBZ_QUOT(32'hFFFF_FFFF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_div(signed_div),
        .opdata1   (opdata1),
        .opdata2   (opdata2),
        .annul     (annul),
        .result    (result),
        .ready     (ready),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    // Drives one operation and measures it; k counts falling edges after the start edge.
    task automatic run_op(input logic sd, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int nrdy, output int nstall,
                          output logic [63:0] res);
        @(negedge clk);
        signed_div = sd;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        #1;
        nstall = stall ? 1 : 0;
        lat    = -1;
        nrdy   = 0;
        res    = '0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (stall) nstall++;
            if (ready) begin
                nrdy++;
                if (lat < 0) begin
                    lat = k;
                    res = result;
                end
            end
            if (k == 1) start = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (result !== 64'd0) begin
            errors++;
            $display("FAIL reset_result: got %h expected %h", result, 64'd0);
        end
        vectors++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 0", ready);
        end
        vectors++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %b expected 0", stall);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        int lat, nrdy, nstall;
        logic [63:0] res;
        run_op(1'b0, 32'd100, 32'd7, lat, nrdy, nstall, res);
        vectors++;
        if (lat !== 34) begin
            errors++;
            $display("FAIL udiv_latency: got %0d expected 34", lat);
        end
        vectors++;
        if (nrdy !== 1) begin
            errors++;
            $display("FAIL udiv_ready_count: got %0d expected 1", nrdy);
        end
        vectors++;
        if (nstall !== 33) begin
            errors++;
            $display("FAIL udiv_stall_cycles: got %0d expected 33", nstall);
        end
        vectors++;
        if (res !== {32'd2, 32'd14}) begin
            errors++;
            $display("FAIL udiv_result: got %h expected %h", res, {32'd2, 32'd14});
        end
    endtask

    task automatic test_signed();
        int lat, nrdy, nstall;
        logic [63:0] res;
        run_op(1'b1, 32'hFFFF_FFF9, 32'h2, lat, nrdy, nstall, res);
        vectors++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            errors++;
            $display("FAIL sdiv_neg7_2: got %h expected %h", res, 64'hFFFF_FFFF_FFFF_FFFD);
        end
        vectors++;
        if (lat !== 34) begin
            errors++;
            $display("FAIL sdiv_latency: got %0d expected 34", lat);
        end
        run_op(1'b0, 32'hFFFF_FFF9, 32'h2, lat, nrdy, nstall, res);
        vectors++;
        if (res !== 64'h0000_0001_7FFF_FFFC) begin
            errors++;
            $display("FAIL udiv_big_2: got %h expected %h", res, 64'h0000_0001_7FFF_FFFC);
        end
    endtask

    task automatic test_dbz();
        int lat, nrdy, nstall;
        logic [63:0] res;
        run_op(1'b0, 32'h1234, 32'h0, lat, nrdy, nstall, res);
        vectors++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL dbz_latency: got %0d expected 3", lat);
        end
        vectors++;
        if (nstall !== 2) begin
            errors++;
            $display("FAIL dbz_stall_cycles: got %0d expected 2", nstall);
        end
        vectors++;
        if (nrdy !== 1) begin
            errors++;
            $display("FAIL dbz_ready_count: got %0d expected 1", nrdy);
        end
        vectors++;
        if (res !== 64'h0000_1234_FFFF_FFFF) begin
            errors++;
            $display("FAIL dbz_result: got %h expected %h", res, 64'h0000_1234_FFFF_FFFF);
        end
    endtask

    task automatic test_overflow();
        int lat, nrdy, nstall;
        logic [63:0] res;
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, nrdy, nstall, res);
        vectors++;
        if (res !== 64'h0000_0000_8000_0000) begin
            errors++;
            $display("FAIL ovf_result: got %h expected %h", res, 64'h0000_0000_8000_0000);
        end
        vectors++;
        if (nrdy !== 1) begin
            errors++;
            $display("FAIL ovf_ready_count: got %0d expected 1", nrdy);
        end
    endtask

    task automatic test_annul();
        int nrdy = 0;
        int lat, n2, nstall;
        logic [63:0] res;
        @(negedge clk);
        signed_div = 1'b0;
        opdata1    = 32'd100;
        opdata2    = 32'd7;
        start      = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (ready) nrdy++;
            if (k == 1) start = 1'b0;
        end
        vectors++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL annul_busy_before: got %b expected 1", stall);
        end
        annul = 1'b1;
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL annul_stall_comb: got %b expected 0", stall);
        end
        @(negedge clk);
        annul = 1'b0;
        if (ready) nrdy++;
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL annul_idle_stall: got %b expected 0", stall);
        end
        vectors++;
        if (nrdy !== 0) begin
            errors++;
            $display("FAIL annul_no_ready: got %0d expected 0", nrdy);
        end
        vectors++;
        if (result !== 64'h0000_0000_8000_0000) begin
            errors++;
            $display("FAIL annul_result_held: got %h expected %h", result,
                     64'h0000_0000_8000_0000);
        end
        run_op(1'b0, 32'd100, 32'd7, lat, n2, nstall, res);
        vectors++;
        if (res !== {32'd2, 32'd14} || lat !== 34) begin
            errors++;
            $display("FAIL annul_restart: got %h lat %0d expected %h lat 34", res, lat,
                     {32'd2, 32'd14});
        end
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int second = -1;
        logic [63:0] r2 = '0;
        @(negedge clk);
        signed_div = 1'b0;
        opdata1    = 32'd100;
        opdata2    = 32'd7;
        start      = 1'b1;
        for (int k = 1; k <= 40 && first < 0; k++) begin
            @(negedge clk);
            if (ready) begin
                first = k;
                vectors++;
                if (result !== {32'd2, 32'd14}) begin
                    errors++;
                    $display("FAIL b2b_first_result: got %h expected %h", result,
                             {32'd2, 32'd14});
                end
                vectors++;
                if (stall !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_stall_on_ready: got %b expected 1", stall);
                end
                signed_div = 1'b1;
                opdata1    = 32'hFFFF_FFF9;
                opdata2    = 32'h2;
            end
        end
        for (int j = 1; j <= 40 && second < 0; j++) begin
            @(negedge clk);
            if (j == 1) start = 1'b0;
            if (ready) begin
                second = j;
                r2     = result;
            end
        end
        vectors++;
        if (first !== 34 || second !== 34) begin
            errors++;
            $display("FAIL b2b_latency: got %0d/%0d expected 34/34", first, second);
        end
        vectors++;
        if (r2 !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            errors++;
            $display("FAIL b2b_second_result: got %h expected %h", r2, 64'hFFFF_FFFF_FFFF_FFFD);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        signed_div = 1'b0;
        opdata1    = 32'd100;
        opdata2    = 32'd7;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_busy: got %b expected 1", stall);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (stall !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ctrl: got stall %b ready %b expected 0 0", stall, ready);
        end
        vectors++;
        if (result !== 64'd0) begin
            errors++;
            $display("FAIL rstmid_result: got %h expected %h", result, 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (stall !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after: got stall %b ready %b expected 0 0", stall, ready);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_dbz();
        test_overflow();
        test_annul();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
Multi-cycle 32-bit integer divider sequencer for the EX stage. It serves DIV and DIVU, the decoder's hilowrite/hiloalu instruction class. It latches the operands, runs a radix-2 restoring division one bit per cycle and stalls the pipeline while busy. On completion it presents {remainder, quotient} to be written into HI/LO. It accepts a flush (annul) from the hazard unit.

Parameters:
WIDTH, 32, operand width in bits; result is 2*WIDTH.
DBZ_QUOT, {WIDTH{1'b1}}, quotient returned on divide-by-zero.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset; asynchronous, active-high.
start  in  1  request from EX stage; sampled only in IDLE.
signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
opdata1  in  WIDTH  dividend (rs); sampled with start.
opdata2  in  WIDTH  divisor (rt); sampled with start.
annul  in  1  flush or exception; aborts the operation in flight.
result  out  2*WIDTH  {hi=remainder, lo=quotient}.
ready  out  1  one-cycle pulse; result valid for HI/LO write.
stall  out  1  freeze PC/IF/ID/EX while asserted.

Behaviour:
- States: IDLE, DBZ, ON, END. 6-bit counter cnt.
- Reset (asynchronous): state=IDLE, cnt=0, result=0, ready=0, internal dividend/divisor/sign registers=0.
- IDLE:
  - start=1 and annul=0: latch operands, sign and signed_div.
  - opdata2==0: go to DBZ.
  - otherwise: go to ON with cnt=0.
  - In signed mode, latch the magnitudes |opdata1| and |opdata2|. Two's-complement negate, WIDTH-bit wrap.
  - Record qneg = op1[msb]^op2[msb] and rneg = op1[msb], both only when signed.
- ON:
  - Each cycle, shift the partial remainder left by 1 and bring in the next dividend bit, MSB first.
  - Trial subtract the divisor at WIDTH+1 bits.
  - Non-negative difference: keep it and set quotient bit=1. Otherwise restore and set quotient bit=0.
  - cnt increments every cycle. After WIDTH ON cycles (cnt==WIDTH-1 processed), go to END.
- END:
  - Apply signs: quotient negated if qneg, remainder negated if rneg.
  - Register result, ready=1 for exactly this cycle, then return to IDLE.
- DBZ: one cycle, then END with quotient=DBZ_QUOT and remainder=latched dividend, unsigned copy, no sign fixups.
- Latency: start sampled at edge E0 gives ready high in the cycle after edge E0+WIDTH+1, i.e. 34 cycles for WIDTH=32. Divide-by-zero gives ready in the cycle after edge E0+2.
- stall = (IDLE & start & ~annul) | ON | DBZ. It is 0 in END, so EX advances while ready=1.
- result holds its value after END until the next END. It does not change on start or annul.
- annul=1 in any state other than IDLE: next edge goes to IDLE, ready stays 0, result is unchanged, stall drops the same cycle (combinational).
  - annul has priority over start and over END; no ready pulse is issued.
- start while not in IDLE: ignored.
- Operand changes after the start edge: ignored.
- Overflow case, signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. This falls out of the WIDTH-bit wrap and needs no trap.
- Back-to-back operations: start held high in the cycle after END's ready is accepted as a new operation.

Test Plan:
- Unsigned 100/7, start one cycle -> stall high 33 cycles, ready pulses once 34 cycles after the start edge, result={32'd2, 32'd14}.
- Signed -7/2 (0xFFFFFFF9, 0x2) -> result={0xFFFFFFFF, 0xFFFFFFFD}; the same operands unsigned -> result={0x1, 0x7FFFFFFC}.
- Divide by zero, opdata1=0x1234 -> ready after 3 cycles, result={0x00001234, 0xFFFFFFFF}, stall high exactly 2 cycles.
- Signed 0x80000000/0xFFFFFFFF -> result={0x0, 0x80000000}, no ready glitch.
- annul asserted on ON cycle 10 of 100/7 -> stall drops the same cycle, no ready pulse, result keeps its prior value. A new start 2 cycles later completes normally.
- rst asserted mid-ON between clock edges -> state IDLE immediately, stall=0, ready=0, result=0.
